// File: rtl/uart_txbuf_pkg.sv
// uart_txbuf_pkg: handshake FSM state encodings and XON/XOFF character codes
// shared by the DZ11 line transmit and receive paths.
package uart_txbuf_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, BUSY = 2'd2, SEND = 2'd3} state_t;
  localparam logic [7:0] XON_CHAR  = 8'h11;
  localparam logic [7:0] XOFF_CHAR = 8'h13;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_wr, do_rd;
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wdata;
endmodule

// File: rtl/uart_txbuf.sv
// uart_txbuf: DZ11 transmit holding FIFO feeding an unbuffered UART transmitter.
// Define UARTTXBUF_XONXOFF_EN to enable XON/XOFF output pausing.
module uart_txbuf
  import uart_txbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [7:0]               wdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovr,
  output logic                     intr,
  input  logic                     xon,
  input  logic                     xoff,
  output logic                     stopped,
  output logic                     txLoad,
  output logic [7:0]               txData,
  input  logic                     txEmpty,
  input  logic                     txIntr
);
  state_t     state, nxt;
  logic [7:0] head;
  logic       empty;
  uart_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr(wr), .wdata(wdata), .rd(state == LOAD),
    .rdata(head), .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= clr ? IDLE : nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = (!empty && txEmpty && !stopped) ? LOAD : IDLE;
      LOAD:    nxt = BUSY;
      BUSY:    nxt = txEmpty ? BUSY : SEND;
      SEND:    nxt = txIntr ? IDLE : SEND;
      default: nxt = IDLE;
    endcase
  end
  // txData is captured on the IDLE->LOAD edge so it is stable while txLoad is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      txLoad <= 1'b0;
      txData <= '0;
      intr   <= 1'b0;
      ovr    <= 1'b0;
    end else if (clr) begin
      txLoad <= 1'b0;
      txData <= '0;
      intr   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      txLoad <= nxt == LOAD;
      if (state == IDLE && nxt == LOAD) txData <= head;
      intr   <= state == SEND && txIntr && empty;
      ovr    <= ovr | (wr && full);
    end
`ifdef UARTTXBUF_XONXOFF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stopped <= 1'b0;
    else if (clr) stopped <= 1'b0;
    else stopped <= xoff | (stopped & !xon);
`else
  logic fc_unused;
  assign fc_unused = xon | xoff;
  assign stopped   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_txbuf.sv
// tb_uart_txbuf: randomized scoreboard bench for uart_txbuf with a behavioural
// transmitter model; honours UARTTXBUF_XONXOFF_EN like the design.
module tb_uart_txbuf;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n, clr, wr, xon, xoff, txEmpty, txIntr;
  logic [7:0] wdata, txData;
  logic full, ovr, intr, stopped, txLoad;
  logic [$clog2(DEPTH):0] level;
  int tests = 0, fails = 0, cyc_n = 0, loads = 0, intr_cnt = 0, last_wr_cyc = 0;
  logic [7:0] sb[$];
  int load_q[$], tint_q[$];
  bit acc_now = 0, ovr_now = 0, char_active = 0, exp_intr = 0, exp_ovr = 0, exp_stop = 0;

  uart_txbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .wdata(wdata),
    .full(full), .level(level), .ovr(ovr), .intr(intr),
    .xon(xon), .xoff(xoff), .stopped(stopped),
    .txLoad(txLoad), .txData(txData), .txEmpty(txEmpty), .txIntr(txIntr)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc_n++; end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_flush();
    sb.delete();
    char_active = 0;
    exp_intr = 0;
    exp_ovr = 0;
    exp_stop = 0;
  endtask

  // one clock of stimulus; the byte enters the expected stream only if the FIFO has room
  task automatic cyc(input bit w, input logic [7:0] d, input bit xn, input bit xf);
    @(posedge clk); #1;
    wr = w; wdata = d; xon = xn; xoff = xf;
    acc_now = 0; ovr_now = 0;
    if (w) begin
      last_wr_cyc = cyc_n;
      if (sb.size() < DEPTH) begin sb.push_back(d); acc_now = 1; end
      else ovr_now = 1;
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    wr = 0; xon = 0; xoff = 0; acc_now = 0; ovr_now = 0; clr = 1;
    @(posedge clk); #1;
    clr = 0;
    model_flush();
  endtask

  task automatic wait_loads(input int n);
    int b = 0;
    while (loads < n && b < 200) begin @(negedge clk); b++; end
    chk("load_timeout", int'(loads >= n), 1);
  endtask

  task automatic drain();
    int b = 0;
    while ((sb.size() != 0 || char_active) && b < 400) begin cyc(0, 8'h00, exp_stop, 0); b++; end
    repeat (3) cyc(0, 8'h00, 0, 0);
    chk("drain_left", sb.size(), 0);
  endtask

  // transmitter: goes busy after a load, finishes 1..4 cycles later unless cleared
  initial begin
    txEmpty = 1; txIntr = 0;
    forever begin
      @(negedge clk);
      if (rst_n && !clr && txLoad) begin
        char_active = 1;
        @(posedge clk); #1 txEmpty = 0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        if (char_active) begin
          txIntr = 1; txEmpty = 1;
          @(posedge clk); #1 txIntr = 0;
          char_active = 0;
        end else txEmpty = 1;
      end
    end
  end

  // monitor: compares every observable output each cycle against the scoreboard model
  initial forever begin
    int lvl;
    @(negedge clk);
    if (!rst_n || clr) continue;
    lvl = sb.size() - int'(acc_now);
    chk("level", int'(level), lvl);
    chk("full", int'(full), int'(lvl == DEPTH));
    chk("ovr", int'(ovr), int'(exp_ovr));
    chk("intr", int'(intr), int'(exp_intr));
    chk("stopped", int'(stopped), int'(exp_stop));
    if (txLoad) begin
      loads++;
      load_q.push_back(cyc_n);
      if (sb.size() == 0) chk("unexpected_load", 1, 0);
      else chk("txData", int'(txData), int'(sb.pop_front()));
    end
    if (intr) intr_cnt++;
    if (txIntr) tint_q.push_back(cyc_n);
    exp_intr = txIntr && char_active && lvl == 0;
    exp_ovr = exp_ovr | ovr_now;
`ifdef UARTTXBUF_XONXOFF_EN
    exp_stop = xoff ? 1'b1 : (xon ? 1'b0 : exp_stop);
`endif
  end

  initial begin
    int l0, ic0;
    rst_n = 0; clr = 0; wr = 0; wdata = 0; xon = 0; xoff = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_full", full, 0); chk("rst_level", level, 0); chk("rst_ovr", ovr, 0);
    chk("rst_intr", intr, 0); chk("rst_stopped", stopped, 0);
    chk("rst_txLoad", txLoad, 0); chk("rst_txData", txData, 0);
    rst_n = 1;
    repeat (2) cyc(0, 8'h00, 0, 0);

    // single byte: load two cycles after the write, intr after its completion
    load_q.delete(); ic0 = intr_cnt;
    cyc(1, 8'h41, 0, 0);
    cyc(0, 8'h00, 0, 0);
    wait_loads(1);
    chk("load_latency", load_q.size() > 0 ? load_q[0] - last_wr_cyc : -1, 2);
    drain();
    chk("intr_single", intr_cnt - ic0, 1);
    chk("level_after", level, 0);

    // overflow with the transmitter busy: 5th byte dropped, ovr sticky until clr
    txEmpty = 0; l0 = loads;
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("ovr_set", ovr, 1);
    chk("full_set", full, 1);
    txEmpty = 1;
    drain();
    chk("ovr_loads", loads - l0, 4);
    chk("ovr_sticky", ovr, 1);
    do_clr();
    chk("clr_ovr", ovr, 0);

    // three queued bytes: next load exactly 2 cycles after each txIntr
    txEmpty = 0; load_q.delete(); tint_q.delete(); ic0 = intr_cnt;
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(0, 8'h00, 0, 0);
    txEmpty = 1;
    drain();
    chk("b2b_loads", load_q.size(), 3);
    for (int i = 1; i < 3 && i < load_q.size() && i <= tint_q.size(); i++)
      chk("b2b_gap", load_q[i] - tint_q[i-1], 2);
    chk("b2b_intr", intr_cnt - ic0, 1);

    // flow control during the first of three characters
    txEmpty = 0; l0 = loads;
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h60 + i), 0, 0);
    cyc(0, 8'h00, 0, 0);
    txEmpty = 1;
    wait_loads(l0 + 1);
    cyc(0, 8'h00, 0, 1);
`ifdef UARTTXBUF_XONXOFF_EN
    repeat (20) cyc(0, 8'h00, 0, 0);
    chk("xoff_hold", loads - l0, 1);
    chk("xoff_stopped", stopped, 1);
    cyc(0, 8'h00, 1, 1);
    repeat (10) cyc(0, 8'h00, 0, 0);
    chk("both_stopped", stopped, 1);
    chk("both_hold", loads - l0, 1);
    cyc(0, 8'h00, 1, 0);
`endif
    drain();
    chk("flow_loads", loads - l0, 3);
    chk("flow_resumed", stopped, 0);

    // async reset while BUSY with two bytes queued
    txEmpty = 0; l0 = loads;
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
    cyc(0, 8'h00, 0, 0);
    txEmpty = 1;
    wait_loads(l0 + 1);
    @(posedge clk); #1;
    rst_n = 0;
    model_flush();
    #1;
    chk("arst_full", full, 0); chk("arst_level", level, 0); chk("arst_ovr", ovr, 0);
    chk("arst_intr", intr, 0); chk("arst_stopped", stopped, 0);
    chk("arst_txLoad", txLoad, 0); chk("arst_txData", txData, 0);
    @(posedge clk); #1 rst_n = 1;
    l0 = loads;
    repeat (20) cyc(0, 8'h00, 0, 0);
    chk("arst_noload", loads - l0, 0);

    // randomized traffic with occasional overruns and flow-control pulses
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    drain();
    do_clr();
    repeat (2) cyc(0, 8'h00, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
